// File: rtl/axi_bram_writer_if.sv
// AXI4-Lite write slave bundle plus BRAM port A, shared by the writer and its bench.
// slave: the writer's view; master: the AXI initiator driving it and watching the BRAM port.
interface axi_bram_writer_if #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10
) ();
    logic [AXI_ADDR_WIDTH-1:0]    s_axi_awaddr;
    logic                         s_axi_awvalid;
    logic                         s_axi_awready;
    logic [AXI_DATA_WIDTH-1:0]    s_axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0]  s_axi_wstrb;
    logic                         s_axi_wvalid;
    logic                         s_axi_wready;
    logic [1:0]                   s_axi_bresp;
    logic                         s_axi_bvalid;
    logic                         s_axi_bready;
    logic [AXI_ADDR_WIDTH-1:0]    s_axi_araddr;
    logic                         s_axi_arvalid;
    logic                         s_axi_arready;
    logic [AXI_DATA_WIDTH-1:0]    s_axi_rdata;
    logic [1:0]                   s_axi_rresp;
    logic                         s_axi_rvalid;
    logic                         s_axi_rready;
    logic                         bram_porta_clk;
    logic                         bram_porta_rst;
    logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr;
    logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata;
    logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output bram_porta_clk, bram_porta_rst, bram_porta_addr, bram_porta_wrdata, bram_porta_we
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  bram_porta_clk, bram_porta_rst, bram_porta_addr, bram_porta_wrdata, bram_porta_we
    );
endinterface

// File: rtl/axi_bram_writer.sv
// Write-only AXI4-Lite to BRAM bridge: one AW and one W slot, BRAM write the cycle after both fill, response next.
// Backpressure: a pending bvalid blocks the next write; full slots drop their ready. AXI_BRAM_WRITER_WSTRB_EN enables byte strobes.
module axi_bram_writer #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10
) (
    input  logic               aclk,
    input  logic               aresetn,
    axi_bram_writer_if.slave   bus
);
    localparam int STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int WE_W     = BRAM_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);

    logic                       en_q;
    logic                       aw_full_q, aw_full_d;
    logic                       w_full_q, w_full_d;
    logic                       bvalid_q, bvalid_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BRAM_DATA_WIDTH-1:0] data_q, data_d;
`ifdef AXI_BRAM_WRITER_WSTRB_EN
    logic [STRB_W-1:0]          strb_q, strb_d;
`endif

    logic aw_hs, w_hs, fire;
    logic unused_inputs;

    assign bus.s_axi_awready = en_q & ~aw_full_q;
    assign bus.s_axi_wready  = en_q & ~w_full_q;
    assign aw_hs = bus.s_axi_awvalid & bus.s_axi_awready;
    assign w_hs  = bus.s_axi_wvalid & bus.s_axi_wready;
    assign fire  = aw_full_q & w_full_q & ~bvalid_q;

    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_bresp   = 2'b00;
    assign bus.s_axi_arready = 1'b0;
    assign bus.s_axi_rdata   = '0;
    assign bus.s_axi_rresp   = 2'b00;
    assign bus.s_axi_rvalid  = 1'b0;

    assign bus.bram_porta_clk    = aclk;
    assign bus.bram_porta_rst    = ~aresetn;
    assign bus.bram_porta_addr   = addr_q;
    assign bus.bram_porta_wrdata = data_q;
`ifdef AXI_BRAM_WRITER_WSTRB_EN
    assign bus.bram_porta_we = fire ? strb_q : '0;
    assign unused_inputs = ^{bus.s_axi_araddr, bus.s_axi_arvalid, bus.s_axi_rready, bus.s_axi_awaddr};
`else
    assign bus.bram_porta_we = fire ? {WE_W{1'b1}} : '0;
    assign unused_inputs = ^{bus.s_axi_araddr, bus.s_axi_arvalid, bus.s_axi_rready, bus.s_axi_awaddr,
                             bus.s_axi_wstrb};
`endif

    // Handshakes need an empty slot and fire needs both full, so the two never collide on a slot.
    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        bvalid_d  = bvalid_q;
        addr_d    = addr_q;
        data_d    = data_q;
`ifdef AXI_BRAM_WRITER_WSTRB_EN
        strb_d    = strb_q;
`endif
        if (aw_hs) begin
            aw_full_d = 1'b1;
            addr_d    = bus.s_axi_awaddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            data_d   = bus.s_axi_wdata;
`ifdef AXI_BRAM_WRITER_WSTRB_EN
            strb_d   = bus.s_axi_wstrb;
`endif
        end
        if (fire) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else if (bvalid_q && bus.s_axi_bready) begin
            bvalid_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            en_q      <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
`ifdef AXI_BRAM_WRITER_WSTRB_EN
            strb_q    <= '0;
`endif
        end else begin
            en_q      <= 1'b1;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
`ifdef AXI_BRAM_WRITER_WSTRB_EN
            strb_q    <= strb_d;
`endif
        end
    end
endmodule

// File: tb/tb_axi_bram_writer.sv
// Directed bench for axi_bram_writer: vector table for steady-state traffic, hand sequences for
// response backpressure and mid-transaction reset.
module tb_axi_bram_writer;
    logic aclk;
    logic aresetn;
    int   n_cmp;
    int   n_err;

    axi_bram_writer_if bus_if ();

    axi_bram_writer dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

`ifdef AXI_BRAM_WRITER_WSTRB_EN
    localparam logic [3:0] WE_0101 = 4'b0101;
`else
    localparam logic [3:0] WE_0101 = 4'hF;
`endif

    typedef struct {
        logic        awv;
        logic [15:0] awa;
        logic        wv;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        br;
        logic        e_awr;
        logic        e_wr;
        logic [3:0]  e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_dat;
        logic        e_bv;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic awv, input logic [15:0] awa, input logic wv,
                         input logic [31:0] wd, input logic [3:0] ws, input logic br);
        bus_if.s_axi_awvalid = awv;
        bus_if.s_axi_awaddr  = awa;
        bus_if.s_axi_wvalid  = wv;
        bus_if.s_axi_wdata   = wd;
        bus_if.s_axi_wstrb   = ws;
        bus_if.s_axi_bready  = br;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic awr, input logic wr,
                             input logic [3:0] we, input logic bv);
        chk({tag, ".awready"}, {63'd0, bus_if.s_axi_awready}, {63'd0, awr});
        chk({tag, ".wready"},  {63'd0, bus_if.s_axi_wready},  {63'd0, wr});
        chk({tag, ".we"},      {60'd0, bus_if.bram_porta_we}, {60'd0, we});
        chk({tag, ".bvalid"},  {63'd0, bus_if.s_axi_bvalid},  {63'd0, bv});
    endtask

    task automatic chk_write(input string tag, input logic [9:0] addr, input logic [31:0] dat);
        chk({tag, ".addr"},   {54'd0, bus_if.bram_porta_addr},   {54'd0, addr});
        chk({tag, ".wrdata"}, {32'd0, bus_if.bram_porta_wrdata}, {32'd0, dat});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        // rows: {awv, awaddr, wv, wdata, wstrb, bready, exp awready, wready, we, addr, wrdata, bvalid}
        tbl[0]  = '{1'b1, 16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b1, 4'h0, 10'd0,    32'h0,        1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 10'd4,    32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 10'd0,    32'h0,        1'b1};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 10'd0,    32'h0,        1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 32'h12345678, 4'hF, 1'b1, 1'b1, 1'b1, 4'h0, 10'd0,    32'h0,        1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 10'd0,    32'h0,        1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 10'd0,    32'h0,        1'b0};
        tbl[7]  = '{1'b1, 16'h0FFC, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 10'd0,    32'h0,        1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 10'd1023, 32'h12345678, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 10'd0,    32'h0,        1'b1};
        tbl[10] = '{1'b1, 16'h1004, 1'b1, 32'hA5A5A5A5, 4'h5, 1'b1, 1'b1, 1'b1, 4'h0, 10'd0,    32'h0,        1'b0};
        tbl[11] = '{1'b1, 16'h0008, 1'b1, 32'h0BADF00D, 4'hF, 1'b1, 1'b0, 1'b0, WE_0101, 10'd1, 32'hA5A5A5A5, 1'b0};
        tbl[12] = '{1'b1, 16'h0008, 1'b1, 32'h0BADF00D, 4'hF, 1'b1, 1'b1, 1'b1, 4'h0, 10'd0,    32'h0,        1'b1};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 10'd2,    32'h0BADF00D, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 10'd0,    32'h0,        1'b1};
        tbl[15] = '{1'b0, 16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 10'd0,    32'h0,        1'b0};

        aresetn = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0);
        bus_if.s_axi_araddr  = 16'h0;
        bus_if.s_axi_arvalid = 1'b0;
        bus_if.s_axi_rready  = 1'b0;

        // Reset: readies held low, no response, BRAM reset follows aresetn
        repeat (3) step();
        chk_state("rst", 1'b0, 1'b0, 4'h0, 1'b0);
        chk("rst.bram_rst", {63'd0, bus_if.bram_porta_rst}, 64'd1);
        aresetn = 1'b1;
        #1;
        chk_state("rel0", 1'b0, 1'b0, 4'h0, 1'b0);
        step();
        chk_state("rel1", 1'b1, 1'b1, 4'h0, 1'b0);
        chk("rel1.bram_rst", {63'd0, bus_if.bram_porta_rst}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].awv, tbl[i].awa, tbl[i].wv, tbl[i].wd, tbl[i].ws, tbl[i].br);
            #1;
            chk_state($sformatf("vec%0d", i), tbl[i].e_awr, tbl[i].e_wr, tbl[i].e_we, tbl[i].e_bv);
            chk($sformatf("vec%0d.bresp", i), {62'd0, bus_if.s_axi_bresp}, 64'd0);
            if (tbl[i].e_we != 4'h0)
                chk_write($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_dat);
            step();
        end

        // Read channel stays dead even when probed
        bus_if.s_axi_arvalid = 1'b1;
        bus_if.s_axi_araddr  = 16'h0040;
        bus_if.s_axi_rready  = 1'b1;
        #1;
        chk("rd.arready", {63'd0, bus_if.s_axi_arready}, 64'd0);
        chk("rd.rvalid",  {63'd0, bus_if.s_axi_rvalid},  64'd0);
        chk("rd.rdata",   {32'd0, bus_if.s_axi_rdata},   64'd0);
        bus_if.s_axi_arvalid = 1'b0;
        bus_if.s_axi_rready  = 1'b0;

        // Response backpressure: second write waits behind an unacknowledged bvalid
        drive(1'b1, 16'h0020, 1'b1, 32'h11111111, 4'hF, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0);
        #1;
        chk_state("bp.fire1", 1'b0, 1'b0, 4'hF, 1'b0);
        chk_write("bp.fire1", 10'd8, 32'h11111111);
        step();
        drive(1'b1, 16'h0024, 1'b1, 32'h22222222, 4'hF, 1'b0);
        #1;
        chk_state("bp.accept2", 1'b1, 1'b1, 4'h0, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_state($sformatf("bp.hold%0d", i), 1'b0, 1'b0, 4'h0, 1'b1);
            step();
        end
        bus_if.s_axi_bready = 1'b1;
        #1;
        chk_state("bp.ack", 1'b0, 1'b0, 4'h0, 1'b1);
        step();
        chk_state("bp.fire2", 1'b0, 1'b0, 4'hF, 1'b0);
        chk_write("bp.fire2", 10'd9, 32'h22222222);
        step();
        chk_state("bp.resp2", 1'b1, 1'b1, 4'h0, 1'b1);
        step();
        chk_state("bp.idle", 1'b1, 1'b1, 4'h0, 1'b0);

        // Reset between acceptance and fire drops the held write entirely
        drive(1'b1, 16'h0030, 1'b1, 32'h33333333, 4'hF, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1);
        aresetn = 1'b0;
        #1;
        chk_state("mrst.async", 1'b0, 1'b0, 4'h0, 1'b0);
        step();
        chk_state("mrst.hold", 1'b0, 1'b0, 4'h0, 1'b0);
        aresetn = 1'b1;
        step();
        chk_state("mrst.rel", 1'b1, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("mrst.idle%0d", i), 1'b1, 1'b1, 4'h0, 1'b0);
        end

        // AW-only traffic fills its slot and stalls
        drive(1'b1, 16'h0044, 1'b0, 32'h0, 4'h0, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_state($sformatf("awonly%0d", i), 1'b0, 1'b1, 4'h0, 1'b0);
            step();
        end
        drive(1'b0, 16'h0, 1'b1, 32'hCAFEF00D, 4'hF, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1);
        #1;
        chk_state("awonly.fire", 1'b0, 1'b0, 4'hF, 1'b0);
        chk_write("awonly.fire", 10'd17, 32'hCAFEF00D);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
